// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_arbiter
// Purpose  : Round-robin arbiter and transaction sequencer sharing one 16-bit
//            data-memory port between NUM_CORES processing cores. One core is
//            granted at a time; the arbiter issues a single memory strobe,
//            waits MEM_LATENCY cycles, captures read data and pulses the
//            granted core's acknowledge.
// Ports    : clk, reset     - clock, synchronous active-high reset
//            req/we         - per-core request level and direction (1 = write)
//            addr/wdata     - per-core address / write data, core i in slot i
//            gnt/ack        - one-hot grant (whole transaction) / done pulse
//            rdata          - last read data, broadcast to all cores
//            busy           - high whenever a transaction is in flight
//            mem_*          - shared memory port
// Revision : 1.0 - initial release
// ============================================================================
module mem_bus_arbiter #(
    parameter int NUM_CORES   = 4,
    parameter int ADDR_W      = 16,
    parameter int MEM_LATENCY = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_CORES-1:0]      req,
    input  logic [NUM_CORES-1:0]      we,
    input  logic [NUM_CORES*ADDR_W-1:0] addr,
    input  logic [NUM_CORES*16-1:0]   wdata,
    output logic [NUM_CORES-1:0]      gnt,
    output logic [NUM_CORES-1:0]      ack,
    output logic [15:0]               rdata,
    output logic                      busy,
    output logic                      mem_en,
    output logic                      mem_we,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [15:0]               mem_wdata,
    input  logic [15:0]               mem_rdata
);

    localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int CNT_W = $clog2(MEM_LATENCY + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [IDX_W-1:0]   r_ptr;
    logic [IDX_W-1:0]   r_idx;
    logic [ADDR_W-1:0]  r_addr;
    logic [15:0]        r_wdata;
    logic               r_we;
    logic [CNT_W-1:0]   r_cnt;
    logic [15:0]        r_rdata;

    logic               w_found;
    logic [IDX_W-1:0]   w_win;
    logic [NUM_CORES-1:0] w_onehot;

    // Winner search: first requester at or above the round-robin pointer,
    // wrapping back to core 0.
    always_comb begin
        int j;
        w_found = 1'b0;
        w_win   = '0;
        j       = 0;
        for (int k = 0; k < NUM_CORES; k++) begin
            j = int'(r_ptr) + k;
            if (j >= NUM_CORES) begin
                j = j - NUM_CORES;
            end
            if (!w_found && req[j]) begin
                w_found = 1'b1;
                w_win   = IDX_W'(j);
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and control outputs
    always_comb begin
        w_state_nxt = r_state;
        w_onehot    = NUM_CORES'(1) << r_idx;
        gnt         = '0;
        ack         = '0;
        mem_en      = 1'b0;
        busy        = 1'b1;
        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (w_found) begin
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                gnt         = w_onehot;
                mem_en      = 1'b1;
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                gnt = w_onehot;
                // Counter reaches zero on this edge.
                if (r_cnt == CNT_W'(1)) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                gnt         = w_onehot;
                ack         = w_onehot;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Datapath: request latch, wait counter, read capture, pointer update
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr   <= '0;
            r_idx   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_we    <= 1'b0;
            r_cnt   <= '0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_idx   <= w_win;
                        r_addr  <= addr[int'(w_win)*ADDR_W +: ADDR_W];
                        r_wdata <= wdata[int'(w_win)*16 +: 16];
                        r_we    <= we[w_win];
                    end
                end
                ST_ISSUE: begin
                    r_cnt <= CNT_W'(MEM_LATENCY);
                end
                ST_WAIT: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    if ((r_cnt == CNT_W'(1)) && !r_we) begin
                        r_rdata <= mem_rdata;
                    end
                end
                ST_DONE: begin
                    // Moving past the served core gives every other pending
                    // requester priority over an immediate re-request.
                    if (r_idx == IDX_W'(NUM_CORES - 1)) begin
                        r_ptr <= '0;
                    end else begin
                        r_ptr <= r_idx + IDX_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign mem_we    = r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign rdata     = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_bus_arbiter
// Purpose  : Directed self-checking bench for mem_bus_arbiter. Instance A uses
//            MEM_LATENCY = 2, instance B uses MEM_LATENCY = 1. The memory model
//            returns (mem_addr ^ 16'hBEFF) exactly MEM_LATENCY cycles after
//            mem_en and 16'h0BAD at any other time.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;

    logic [3:0]  req, we, gnt, ack;
    logic [63:0] addr, wdata;
    logic [15:0] rdata, mem_addr, mem_wdata, mem_rdata;
    logic        busy, mem_en, mem_we;

    logic [3:0]  b_req, b_we, b_gnt, b_ack;
    logic [63:0] b_addr, b_wdata;
    logic [15:0] b_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
    logic        b_busy, b_mem_en, b_mem_we;

    logic [1:0]  a_pipe;
    logic        b_pipe;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.NUM_CORES(4), .ADDR_W(16), .MEM_LATENCY(2)) u_dut_a (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr),
        .wdata(wdata), .gnt(gnt), .ack(ack), .rdata(rdata), .busy(busy),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    mem_bus_arbiter #(.NUM_CORES(4), .ADDR_W(16), .MEM_LATENCY(1)) u_dut_b (
        .clk(clk), .reset(reset), .req(b_req), .we(b_we), .addr(b_addr),
        .wdata(b_wdata), .gnt(b_gnt), .ack(b_ack), .rdata(b_rdata), .busy(b_busy),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
    );

    // Memory models: data is only valid in the cycle MEM_LATENCY after mem_en
    always @(posedge clk) begin
        if (reset) begin
            a_pipe <= 2'b00;
            b_pipe <= 1'b0;
        end else begin
            a_pipe <= {a_pipe[0], mem_en};
            b_pipe <= b_mem_en;
        end
    end
    assign mem_rdata   = a_pipe[1] ? (mem_addr ^ 16'hBEFF)   : 16'h0BAD;
    assign b_mem_rdata = b_pipe    ? (b_mem_addr ^ 16'hBEFF) : 16'h0BAD;

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (gnt !== 4'b0)     begin n_fail++; $display("FAIL rst_gnt got %b want 0000", gnt); end
        n_checks++; if (ack !== 4'b0)     begin n_fail++; $display("FAIL rst_ack got %b want 0000", ack); end
        n_checks++; if (rdata !== 16'h0)  begin n_fail++; $display("FAIL rst_rdata got %h want 0000", rdata); end
        n_checks++; if (busy !== 1'b0)    begin n_fail++; $display("FAIL rst_busy got %b want 0", busy); end
        n_checks++; if (mem_en !== 1'b0)  begin n_fail++; $display("FAIL rst_mem_en got %b want 0", mem_en); end
        n_checks++; if (mem_we !== 1'b0)  begin n_fail++; $display("FAIL rst_mem_we got %b want 0", mem_we); end
        n_checks++; if (mem_addr !== 16'h0)  begin n_fail++; $display("FAIL rst_mem_addr got %h want 0000", mem_addr); end
        n_checks++; if (mem_wdata !== 16'h0) begin n_fail++; $display("FAIL rst_mem_wdata got %h want 0000", mem_wdata); end
        n_checks++; if (b_busy !== 1'b0 || b_gnt !== 4'b0) begin n_fail++; $display("FAIL rst_b got busy=%b gnt=%b want 0/0000", b_busy, b_gnt); end
        reset = 1'b0;
    endtask

    task automatic test_single_read;
        logic [3:0] e_gnt, e_ack;
        for (int c = 0; c <= 5; c++) begin
            @(negedge clk);
            e_gnt = (c >= 1 && c <= 4) ? 4'b0100 : 4'b0000;
            e_ack = (c == 4) ? 4'b0100 : 4'b0000;
            n_checks++; if (gnt !== e_gnt) begin n_fail++; $display("FAIL rd_gnt c=%0d got %b want %b", c, gnt, e_gnt); end
            n_checks++; if (ack !== e_ack) begin n_fail++; $display("FAIL rd_ack c=%0d got %b want %b", c, ack, e_ack); end
            n_checks++; if (mem_en !== (c == 1)) begin n_fail++; $display("FAIL rd_mem_en c=%0d got %b want %b", c, mem_en, (c == 1)); end
            n_checks++; if (busy !== (c >= 1 && c <= 4)) begin n_fail++; $display("FAIL rd_busy c=%0d got %b", c, busy); end
            if (c == 1) begin
                n_checks++; if (mem_addr !== 16'h0010 || mem_we !== 1'b0) begin n_fail++; $display("FAIL rd_port got addr=%h we=%b want 0010/0", mem_addr, mem_we); end
            end
            if (c == 4) begin
                n_checks++; if (rdata !== 16'hBEEF) begin n_fail++; $display("FAIL rd_rdata got %h want BEEF", rdata); end
            end
            if (c == 0) begin
                we = 4'b0000; addr[2*16 +: 16] = 16'h0010; req = 4'b0100;
            end
            if (c == 5) req = 4'b0000;
        end
    endtask

    task automatic test_single_write;
        logic [3:0] e_ack;
        for (int c = 0; c <= 5; c++) begin
            @(negedge clk);
            e_ack = (c == 4) ? 4'b0001 : 4'b0000;
            n_checks++; if (ack !== e_ack) begin n_fail++; $display("FAIL wr_ack c=%0d got %b want %b", c, ack, e_ack); end
            n_checks++; if (mem_en !== (c == 1)) begin n_fail++; $display("FAIL wr_mem_en c=%0d got %b want %b", c, mem_en, (c == 1)); end
            if (c >= 1 && c <= 4) begin
                n_checks++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL wr_gnt c=%0d got %b want 0001", c, gnt); end
                n_checks++; if (mem_we !== 1'b1 || mem_addr !== 16'h0003 || mem_wdata !== 16'h1234) begin
                    n_fail++; $display("FAIL wr_port c=%0d got we=%b addr=%h wdata=%h want 1/0003/1234", c, mem_we, mem_addr, mem_wdata);
                end
            end
            if (c == 4) begin
                n_checks++; if (rdata !== 16'hBEEF) begin n_fail++; $display("FAIL wr_rdata got %h want BEEF", rdata); end
            end
            if (c == 0) begin
                we = 4'b0001; addr[0 +: 16] = 16'h0003; wdata[0 +: 16] = 16'h1234; req = 4'b0001;
            end
            if (c == 5) begin req = 4'b0000; we = 4'b0000; end
        end
    endtask

    task automatic test_round_robin;
        logic [3:0]  e_ack;
        logic [15:0] e_rd;
        int          n_acks [4];
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            addr[i*16 +: 16] = 16'h0100 + 16'(i);
            n_acks[i] = 0;
        end
        we = 4'b0000;
        for (int c = 0; c <= 20; c++) begin
            @(negedge clk);
            if (c == 0) req = 4'b1111;
            if (c == 20) req = 4'b0000;
            if (c < 20) begin
                e_ack = (c % 5 == 4) ? (4'b0001 << (c / 5)) : 4'b0000;
                n_checks++; if (ack !== e_ack) begin n_fail++; $display("FAIL rr_ack c=%0d got %b want %b", c, ack, e_ack); end
                for (int i = 0; i < 4; i++) if (ack[i] === 1'b1) n_acks[i]++;
                if (c % 5 == 1) begin
                    n_checks++; if (gnt !== (4'b0001 << (c / 5))) begin n_fail++; $display("FAIL rr_gnt c=%0d got %b want %b", c, gnt, 4'b0001 << (c / 5)); end
                end
                if (c % 5 == 4) begin
                    e_rd = 16'hBFFF ^ 16'(c / 5);
                    n_checks++; if (rdata !== e_rd) begin n_fail++; $display("FAIL rr_rdata c=%0d got %h want %h", c, rdata, e_rd); end
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (n_acks[i] != 1) begin n_fail++; $display("FAIL rr_count core=%0d got %0d want 1", i, n_acks[i]); end
        end
    endtask

    task automatic test_fairness;
        logic [3:0] e_ack;
        addr[1*16 +: 16] = 16'h0011;
        addr[3*16 +: 16] = 16'h0013;
        for (int c = 0; c <= 15; c++) begin
            @(negedge clk);
            e_ack = (c == 4 || c == 14) ? 4'b0010 : (c == 9) ? 4'b1000 : 4'b0000;
            n_checks++; if (ack !== e_ack) begin n_fail++; $display("FAIL fair_ack c=%0d got %b want %b", c, ack, e_ack); end
            if (c == 1 || c == 11) begin
                n_checks++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL fair_gnt c=%0d got %b want 0010", c, gnt); end
            end
            if (c == 6) begin
                n_checks++; if (gnt !== 4'b1000) begin n_fail++; $display("FAIL fair_gnt c=%0d got %b want 1000", c, gnt); end
            end
            if (c == 14) begin
                n_checks++; if (rdata !== 16'hBEEE) begin n_fail++; $display("FAIL fair_rdata got %h want BEEE", rdata); end
            end
            if (c == 0) req = 4'b1010;
            // Core 1 drops its request during its own second transaction.
            if (c == 11) req = 4'b0000;
        end
    endtask

    task automatic test_reset_mid_wait;
        addr[2*16 +: 16] = 16'h0020;
        for (int c = 0; c <= 12; c++) begin
            @(negedge clk);
            if (c == 1) begin
                n_checks++; if (gnt !== 4'b0100) begin n_fail++; $display("FAIL rmw_gnt_pre got %b want 0100", gnt); end
            end
            if (c == 3) begin
                n_checks++; if (gnt !== 4'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rmw_abort got gnt=%b busy=%b want 0000/0", gnt, busy); end
                n_checks++; if (rdata !== 16'h0) begin n_fail++; $display("FAIL rmw_rdata got %h want 0000", rdata); end
                n_checks++; if (mem_addr !== 16'h0 || mem_en !== 1'b0) begin n_fail++; $display("FAIL rmw_port got addr=%h en=%b want 0000/0", mem_addr, mem_en); end
                reset = 1'b0;
            end
            if (c >= 3 && c <= 7) begin
                n_checks++; if (ack !== 4'b0) begin n_fail++; $display("FAIL rmw_no_ack c=%0d got %b want 0000", c, ack); end
            end
            if (c == 8) begin
                n_checks++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL rmw_ptr got %b want 0010", gnt); end
                req = 4'b0000;
            end
            if (c == 11) begin
                n_checks++; if (ack !== 4'b0010) begin n_fail++; $display("FAIL rmw_ack got %b want 0010", ack); end
            end
            if (c == 0) begin we = 4'b0000; req = 4'b0100; end
            if (c == 2) begin reset = 1'b1; req = 4'b0000; end
            if (c == 7) req = 4'b1010;
        end
    endtask

    task automatic test_wrap_lat1;
        logic [3:0] e_ack;
        b_addr[3*16 +: 16] = 16'h0007;
        b_addr[0 +: 16]    = 16'h0005;
        b_we = 4'b0000;
        for (int c = 0; c <= 9; c++) begin
            @(negedge clk);
            e_ack = (c == 3) ? 4'b1000 : (c == 7) ? 4'b0001 : 4'b0000;
            n_checks++; if (b_ack !== e_ack) begin n_fail++; $display("FAIL wrap_ack c=%0d got %b want %b", c, b_ack, e_ack); end
            n_checks++; if (b_mem_en !== (c == 1 || c == 5)) begin n_fail++; $display("FAIL wrap_mem_en c=%0d got %b", c, b_mem_en); end
            if (c == 1) begin
                n_checks++; if (b_gnt !== 4'b1000) begin n_fail++; $display("FAIL wrap_gnt1 got %b want 1000", b_gnt); end
            end
            if (c == 3) begin
                n_checks++; if (b_rdata !== 16'hBEF8) begin n_fail++; $display("FAIL wrap_rdata1 got %h want BEF8", b_rdata); end
            end
            if (c == 5) begin
                n_checks++; if (b_gnt !== 4'b0001) begin n_fail++; $display("FAIL wrap_gnt2 got %b want 0001", b_gnt); end
            end
            if (c == 7) begin
                n_checks++; if (b_rdata !== 16'hBEFA) begin n_fail++; $display("FAIL wrap_rdata2 got %h want BEFA", b_rdata); end
            end
            if (c == 0) b_req = 4'b1000;
            if (c == 4) b_req = 4'b1001;
            if (c == 8) b_req = 4'b0000;
        end
    endtask

    initial begin
        reset = 1'b1;
        req = '0; we = '0; addr = '0; wdata = '0;
        b_req = '0; b_we = '0; b_addr = '0; b_wdata = '0;
        test_reset();
        test_single_read();
        test_single_write();
        test_round_robin();
        test_fairness();
        test_reset_mid_wait();
        test_wrap_lat1();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
